echo_stream_arbiter: RTL
========================

// Module: echo_stream_arbiter
// PURPOSE
//  Shares one stereo echo datapath (valid/ready in, valid/ready out, in-order) between two stereo sources.
//  Round-robin arbiter with a registered issue stage; a tag FIFO records the source of every issued sample.
//  Each result is returned to its originating source, in issue order.
//  Sits between two audio front-ends and the single echo processing pipeline.
// PARAMETERS
//  audio_width      16  bits per channel sample (two's complement)
//  max_outstanding  4   tag FIFO depth = max samples in flight in the datapath; power of 2, >=2
// PORTS
//  clk          in   1            clock
//  reset        in   1            reset, asynchronous, active-high
//  s0_valid     in   1            source 0 sample valid
//  s0_ready     out  1            source 0 sample accepted this cycle when valid&ready
//  s0_left      in   audio_width  source 0 left sample
//  s0_right     in   audio_width  source 0 right sample
//  s1_*         (same four signals as s0_*)  source 1
//  p_i_valid    out  1            issue to datapath valid (registered)
//  p_i_ready    in   1            datapath accepts issue
//  p_i_left     out  audio_width  issued left (registered)
//  p_i_right    out  audio_width  issued right (registered)
//  p_o_valid    in   1            datapath result valid
//  p_o_ready    out  1            result consumed
//  p_o_left     in   audio_width  result left
//  p_o_right    in   audio_width  result right
//  r0_valid     out  1            result for source 0 valid
//  r0_ready     in   1            source 0 takes result
//  r0_left      out  audio_width  result left, source 0
//  r0_right     out  audio_width  result right, source 0
//  r1_*         (same four signals as r0_*)  source 1
//  o_count      out  clog2(max_outstanding)+1  tags outstanding
//  o_err_orphan out  1            sticky: datapath result arrived with no tag
// BEHAVIOUR
//  Reset values: p_i_valid=0, p_i_left/right=0, tag FIFO empty, o_count=0, o_err_orphan=0, rr pointer=0 (source 0 first).
//  slot_free = !p_i_valid | p_i_ready; can_issue = slot_free & (o_count < max_outstanding).
//  Grant (combinational): if one sX_valid, grant it; if both, grant rr pointer; none -> no grant.
//  sX_ready = can_issue & grant==X. Only the granted source sees ready; no combinational path from sX_valid to own ready except via arbitration.
//  On accept: p_i_* <= granted sample, p_i_valid<=1, push tag X, rr pointer <= ~X. Latency source->p_i_valid: 1 cycle.
//  If p_i_valid & p_i_ready & no accept: p_i_valid<=0. Holding p_i_valid & !p_i_ready: p_i_* stable.
//  Result routing (combinational): head = oldest tag. rH_valid = p_o_valid & !empty & head==H; r_other_valid=0.
//  rX_left/right = p_o_left/right, both ports. p_o_ready = !empty & r[head]_ready.
//  On p_o_valid & p_o_ready: pop tag.
//  o_count = pushes - pops (issue register + datapath in flight). Push and pop in the same cycle: count unchanged.
//  Full (o_count==max_outstanding): no accept, even if a pop occurs the same cycle (no bypass); readiness returns next cycle.
//  Empty & p_o_valid: p_o_ready=0, result held off, o_err_orphan<=1 (sticky until reset).
//  Head-of-line: a stalled rX_ready blocks all results and, once full, all issues; this is intended, since the datapath is in-order.
//  Reset mid-operation: all state clears asynchronously; in-flight samples are dropped. The datapath must be reset by the same reset.
//  Arithmetic: none on samples; pass-through, width-exact. FIFO pointers wrap modulo max_outstanding.
// TESTING
//  1 Both sources valid continuously, p_i_ready=1 -> issue order s0,s1,s0,s1...; each rX receives only its own samples.
//  2 s0 only, s0 sends 0x1234/0x8000 -> p_i_valid rises 1 cycle after accept with p_i_left=0x1234, p_i_right=0x8000.
//  3 p_o_ready loop-back stalled, 4 issues accepted -> o_count=4, s0_ready=s1_ready=0; one pop -> ready re-asserts next cycle.
//  4 p_i_ready=0 for 5 cycles with p_i_valid=1 -> p_i_* stable and no further sX_ready.
//  5 r1_ready=0 with head tag=1 -> r0_valid=0 and p_o_ready=0; r1_ready=1 -> pop, then s0 result delivered.
//  6 p_o_valid=1 with FIFO empty -> o_err_orphan=1 and stays 1; async reset mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/echo_stream_arbiter.sv
// Round-robin sharing of one in-order stereo echo datapath between two sources.
// A tag FIFO remembers the source of every issued sample so each result goes back to it.
module echo_stream_arbiter #(
  parameter int audio_width     = 16,
  parameter int max_outstanding = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              s0_valid,
  output logic                              s0_ready,
  input  logic [audio_width-1:0]            s0_left,
  input  logic [audio_width-1:0]            s0_right,
  input  logic                              s1_valid,
  output logic                              s1_ready,
  input  logic [audio_width-1:0]            s1_left,
  input  logic [audio_width-1:0]            s1_right,
  output logic                              p_i_valid,
  input  logic                              p_i_ready,
  output logic [audio_width-1:0]            p_i_left,
  output logic [audio_width-1:0]            p_i_right,
  input  logic                              p_o_valid,
  output logic                              p_o_ready,
  input  logic [audio_width-1:0]            p_o_left,
  input  logic [audio_width-1:0]            p_o_right,
  output logic                              r0_valid,
  input  logic                              r0_ready,
  output logic [audio_width-1:0]            r0_left,
  output logic [audio_width-1:0]            r0_right,
  output logic                              r1_valid,
  input  logic                              r1_ready,
  output logic [audio_width-1:0]            r1_left,
  output logic [audio_width-1:0]            r1_right,
  output logic [$clog2(max_outstanding):0]  o_count,
  output logic                              o_err_orphan
);

  localparam int PW = $clog2(max_outstanding);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(max_outstanding);

  logic                   p_i_valid_q, p_i_valid_d;
  logic [audio_width-1:0] p_i_left_q, p_i_left_d;
  logic [audio_width-1:0] p_i_right_q, p_i_right_d;
  logic                   rr_q, rr_d;
  logic                   tag_q [max_outstanding];
  logic                   tag_d [max_outstanding];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   err_q, err_d;

  logic slot_free, can_issue, any_valid, grant_sel, accept;
  logic empty, head, pop;

  // Arbitration: the rr pointer only matters when both sources compete.
  always_comb begin
    slot_free = !p_i_valid_q || p_i_ready;
    can_issue = slot_free && (count_q < MAX_CNT);
    any_valid = s0_valid || s1_valid;
    grant_sel = (s0_valid && s1_valid) ? rr_q : s1_valid;
    accept    = can_issue && any_valid;
    s0_ready  = accept && !grant_sel;
    s1_ready  = accept && grant_sel;
  end

  // Result routing follows the oldest tag; a stalled head blocks everything behind it.
  always_comb begin
    empty     = (count_q == '0);
    head      = tag_q[rd_ptr_q];
    r0_valid  = p_o_valid && !empty && !head;
    r1_valid  = p_o_valid && !empty && head;
    r0_left   = p_o_left;
    r0_right  = p_o_right;
    r1_left   = p_o_left;
    r1_right  = p_o_right;
    p_o_ready = !empty && (head ? r1_ready : r0_ready);
    pop       = p_o_valid && p_o_ready;
  end

  always_comb begin
    p_i_valid_d = p_i_valid_q;
    p_i_left_d  = p_i_left_q;
    p_i_right_d = p_i_right_q;
    rr_d        = rr_q;
    tag_d       = tag_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_d       = err_q || (p_o_valid && empty);

    if (accept) begin
      p_i_valid_d     = 1'b1;
      p_i_left_d      = grant_sel ? s1_left : s0_left;
      p_i_right_d     = grant_sel ? s1_right : s0_right;
      tag_d[wr_ptr_q] = grant_sel;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      rr_d            = !grant_sel;
    end else if (p_i_valid_q && p_i_ready) begin
      p_i_valid_d = 1'b0;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Count includes the issue register as well as samples inside the datapath.
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_i_valid_q <= 1'b0;
      p_i_left_q  <= '0;
      p_i_right_q <= '0;
      rr_q        <= 1'b0;
      for (int i = 0; i < max_outstanding; i++) tag_q[i] <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      p_i_valid_q <= p_i_valid_d;
      p_i_left_q  <= p_i_left_d;
      p_i_right_q <= p_i_right_d;
      rr_q        <= rr_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign p_i_valid    = p_i_valid_q;
  assign p_i_left     = p_i_left_q;
  assign p_i_right    = p_i_right_q;
  assign o_count      = count_q;
  assign o_err_orphan = err_q;

endmodule
